fault_recovery_ctrl: RTL

Responder to the fault-detector outputs (warning/fault/shutdown).
- Gates the power stage and caps duty on warnings.
- On fault or shutdown: trips the power stage, pulses the detector's active-low reset, waits a cooldown, then soft-starts the duty limit back up.
- After MAX_RETRY trips without a stable run, latches a lockout that only an operator clear releases.

---
 rtl/fault_recovery_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/fault_recovery_ctrl.sv
// rtl/fault_recovery_ctrl.sv - power-stage trip/cooldown/soft-start responder to fault-detector flags
module fault_recovery_ctrl #(
   parameter int COOL_CYCLES   = 1000,
   parameter int RAMP_DIV      = 4,
   parameter int RAMP_STEP     = 8,
   parameter int DERATE_DUTY   = 128,
   parameter int MAX_RETRY     = 3,
   parameter int RST_PULSE     = 2,
   parameter int STABLE_CYCLES = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       clear_req,
   input  logic       warning,
   input  logic       fault,
   input  logic       shutdown,
   output logic       pwr_en,
   output logic [7:0] duty_limit,
   output logic       det_rstn,
   output logic [2:0] retry_cnt,
   output logic       lockout,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_OFF       = 3'd0,
      S_SOFTSTART = 3'd1,
      S_RUN       = 3'd2,
      S_DERATE    = 3'd3,
      S_TRIP      = 3'd4,
      S_COOLDOWN  = 3'd5,
      S_LOCKOUT   = 3'd6
   } state_t;

   localparam logic [15:0] COOL_LAST   = 16'(COOL_CYCLES - 1);
   localparam logic [15:0] RAMP_LAST   = 16'(RAMP_DIV - 1);
   localparam logic [15:0] PULSE_LAST  = 16'(RST_PULSE - 1);
   localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
   localparam logic [7:0]  DERATE_CAP  = 8'(DERATE_DUTY);
   localparam logic [2:0]  RETRY_MAX   = 3'(MAX_RETRY);
   localparam logic [8:0]  STEP9       = 9'(RAMP_STEP);

   state_t      state_q, state_d;
   logic        pwr_q, pwr_d;
   logic [7:0]  duty_q, duty_d;
   logic        rstn_q, rstn_d;
   logic [2:0]  retry_q, retry_d;
   logic        lock_q, lock_d;
   logic [15:0] ramp_q, ramp_d;
   logic [15:0] pulse_q, pulse_d;
   logic [15:0] cool_q, cool_d;
   logic [15:0] stable_q, stable_d;
   logic [8:0]  ramp_sum;
   logic        trip_req;

   assign trip_req = fault | shutdown;
   assign ramp_sum = {1'b0, duty_q} + STEP9;

   always_comb begin
      state_d  = state_q;
      duty_d   = duty_q;
      retry_d  = retry_q;
      ramp_d   = ramp_q;
      pulse_d  = pulse_q;
      cool_d   = cool_q;
      stable_d = '0;
      case (state_q)
         S_OFF: begin
            if (enable) begin
               state_d = S_SOFTSTART;
               ramp_d  = '0;
            end
         end
         S_SOFTSTART: begin
            if (trip_req) begin
               state_d = S_TRIP;
            end else if (!enable) begin
               state_d = S_OFF;
            end else if (duty_q == 8'hFF) begin
               state_d = S_RUN;
            end else if (!warning) begin
               if (ramp_q == RAMP_LAST) begin
                  ramp_d = '0;
                  duty_d = ramp_sum[8] ? 8'hFF : ramp_sum[7:0];
               end else begin
                  ramp_d = ramp_q + 16'd1;
               end
            end
         end
         S_RUN: begin
            if (trip_req) begin
               state_d = S_TRIP;
            end else if (!enable) begin
               state_d = S_OFF;
            end else if (warning) begin
               state_d = S_DERATE;
               duty_d  = (duty_q < DERATE_CAP) ? duty_q : DERATE_CAP;
            end else if (stable_q == STABLE_LAST) begin
               retry_d = '0;
            end else begin
               stable_d = stable_q + 16'd1;
            end
         end
         S_DERATE: begin
            if (trip_req) begin
               state_d = S_TRIP;
            end else if (!enable) begin
               state_d = S_OFF;
            end else if (!warning) begin
               state_d = S_SOFTSTART;
               ramp_d  = '0;
            end
         end
         S_TRIP: begin
            if (pulse_q == PULSE_LAST) begin
               if (retry_q >= RETRY_MAX) begin
                  state_d = S_LOCKOUT;
               end else begin
                  state_d = S_COOLDOWN;
                  cool_d  = '0;
               end
            end else begin
               pulse_d = pulse_q + 16'd1;
            end
         end
         S_COOLDOWN: begin
            if (cool_q == COOL_LAST) begin
               if (trip_req) begin
                  state_d = S_TRIP;
               end else if (enable) begin
                  state_d = S_SOFTSTART;
                  ramp_d  = '0;
               end else begin
                  state_d = S_OFF;
               end
            end else begin
               cool_d = cool_q + 16'd1;
            end
         end
         S_LOCKOUT: begin
            if (clear_req) begin
               state_d = S_OFF;
               retry_d = '0;
            end
         end
         default: state_d = S_OFF;
      endcase

      // Every way into TRIP counts as a retry, including a re-trip straight out of cooldown.
      if (state_d == S_TRIP && state_q != S_TRIP) begin
         retry_d = (retry_q == 3'd7) ? 3'd7 : retry_q + 3'd1;
         pulse_d = '0;
      end

      pwr_d  = (state_d == S_SOFTSTART) || (state_d == S_RUN) || (state_d == S_DERATE);
      rstn_d = (state_d != S_TRIP);
      lock_d = (state_d == S_LOCKOUT);
      if (state_d == S_RUN) begin
         duty_d = 8'hFF;
      end else if (!pwr_d) begin
         duty_d = 8'h00;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_OFF;
         pwr_q    <= 1'b0;
         duty_q   <= '0;
         rstn_q   <= 1'b1;
         retry_q  <= '0;
         lock_q   <= 1'b0;
         ramp_q   <= '0;
         pulse_q  <= '0;
         cool_q   <= '0;
         stable_q <= '0;
      end else begin
         state_q  <= state_d;
         pwr_q    <= pwr_d;
         duty_q   <= duty_d;
         rstn_q   <= rstn_d;
         retry_q  <= retry_d;
         lock_q   <= lock_d;
         ramp_q   <= ramp_d;
         pulse_q  <= pulse_d;
         cool_q   <= cool_d;
         stable_q <= stable_d;
      end
   end

   assign pwr_en     = pwr_q;
   assign duty_limit = duty_q;
   assign det_rstn   = rstn_q;
   assign retry_cnt  = retry_q;
   assign lockout    = lock_q;
   assign state      = state_q;

endmodule
